// File: rtl/sram_like_axi_bridge.sv
// Bridges the core's instruction and data sram-like ports onto a single AXI3 master.
// One transaction in flight at a time; the data port wins arbitration.
module sram_like_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_e;

  state_e      state_q, state_d;
  logic        src_q, src_d;          // 1 = data port owns the transaction
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        grant_data, grant_inst, resp_ok;
  logic [3:0]  src_id;
  logic        unused_resp;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    wr_d       = wr_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    resp_ok    = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_data = data_req & ~rst;
        grant_inst = inst_req & ~data_req & ~rst;
        if (grant_data || grant_inst) begin
          src_d     = grant_data;
          wr_d      = grant_data ? data_wr    : inst_wr;
          size_d    = grant_data ? data_size  : inst_size;
          addr_d    = grant_data ? data_addr  : inst_addr;
          wdata_d   = grant_data ? data_wdata : inst_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wr_d ? S_WR : S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          resp_ok = ~rst;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          resp_ok = ~rst;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wstrb = 4'b1111;
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  assign src_id       = src_q ? DATA_ID : INST_ID;
  assign data_addr_ok = grant_data;
  assign inst_addr_ok = grant_inst;
  assign data_data_ok = resp_ok & src_q;
  assign inst_data_ok = resp_ok & ~src_q;
  assign data_rdata   = rdata;
  assign inst_rdata   = rdata;

  assign arid    = src_id;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = src_id;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid   = src_id;
  assign wdata = wdata_q;
  assign wlast = 1'b1;

  // Response IDs and status codes carry no information for a single-outstanding master.
  assign unused_resp = ^{rid, rresp, bid, bresp, wr_q};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Scoreboard bench for sram_like_axi_bridge: expected responses queued at addr_ok,
// popped and compared when a data_ok pulse appears.
module tb_sram_like_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  sram_like_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        src;   // 1 = data port
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   inst_ok_cnt = 0;
  int   data_ok_cnt = 0;

  function automatic logic [8:0] hs_vec();
    return {arvalid, rready, awvalid, wvalid, bready,
            inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic src, input logic wr, input logic [31:0] d);
    exp_t e;
    e.src = src;
    e.wr = wr;
    e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic set_port(input logic is_data, input logic req, input logic wr,
                          input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd);
    if (is_data) begin
      data_req = req; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = req; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
    end
  endtask

  task automatic clear_inputs();
    set_port(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
  endtask

  task automatic randomize_inputs();
    set_port(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom);
    set_port(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom);
    arready = 1'($urandom_range(0, 1)); rvalid = 1'($urandom_range(0, 1));
    rlast = 1'($urandom_range(0, 1)); rdata = $urandom; rid = 4'($urandom_range(0, 15));
    awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1));
    bvalid = 1'($urandom_range(0, 1));
  endtask

  // Response monitor: every data_ok pulse must match the oldest accepted request.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    if (inst_data_ok) inst_ok_cnt++;
    if (data_data_ok) data_ok_cnt++;
    if (inst_data_ok || data_data_ok) begin
      checks++;
      if (inst_data_ok && data_data_ok) begin
        errors++;
        $display("FAIL both_data_ok inst=%0b data=%0b want only one", inst_data_ok, data_data_ok);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_data_ok inst=%0b data=%0b want none", inst_data_ok, data_data_ok);
      end else begin
        e = sb.pop_front();
        got = e.src ? data_rdata : inst_rdata;
        if (data_data_ok !== e.src) begin
          errors++;
          $display("FAIL data_ok_port got_data_port=%0b want=%0b", data_data_ok, e.src);
        end else if (!e.wr && got !== e.rdata) begin
          errors++;
          $display("FAIL rdata got=%h want=%h", got, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b1;
    randomize_inputs();
    for (int i = 0; i < 2; i++) begin
      step();
      randomize_inputs();
      sample();
      checks++;
      if (hs_vec() !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got=%b want=%b", i, hs_vec(), 9'd0);
      end
    end
    step();
    rst = 1'b0;
    clear_inputs();
    sample();
    checks++;
    if (hs_vec() !== 9'd0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b want=%b", hs_vec(), 9'd0);
    end
  endtask

  task automatic test_inst_read();
    int c0;
    c0 = inst_ok_cnt;
    step();
    set_port(1'b0, 1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0);
    arready = 1'b1;
    sample();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL inst_read_addr_ok got=%b want=10", {inst_addr_ok, data_addr_ok});
    end
    push_exp(1'b0, 1'b0, 32'h3C1D_0010);
    step();
    inst_req = 1'b0;
    sample();
    checks++;
    if ({arvalid, arid, araddr, arsize, arlen, arburst} !==
        {1'b1, 4'd0, 32'hBFC0_0000, 3'd2, 4'd0, 2'b01}) begin
      errors++;
      $display("FAIL inst_read_ar got=%h want=%h", {arvalid, arid, araddr, arsize, arlen, arburst},
               {1'b1, 4'd0, 32'hBFC0_0000, 3'd2, 4'd0, 2'b01});
    end
    step();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h3C1D_0010;
    sample();
    checks++;
    if ({rready, arvalid} !== 2'b10) begin
      errors++;
      $display("FAIL inst_read_rready got=%b want=10", {rready, arvalid});
    end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    sample();
    step();
    sample();
    checks++;
    if (inst_ok_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL inst_read_once got=%0d want=1", inst_ok_cnt - c0);
    end
  endtask

  task automatic test_priority();
    step();
    set_port(1'b0, 1'b1, 1'b0, 2'd2, 32'hBFC0_0004, 32'd0);
    set_port(1'b1, 1'b1, 1'b0, 2'd2, 32'h8000_1000, 32'd0);
    arready = 1'b1;
    sample();
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL prio_grant got=%b want=10", {data_addr_ok, inst_addr_ok});
    end
    push_exp(1'b1, 1'b0, 32'h1111_2222);
    step();
    data_req = 1'b0;
    sample();
    checks++;
    if ({arvalid, arid, araddr, inst_addr_ok} !== {1'b1, 4'd1, 32'h8000_1000, 1'b0}) begin
      errors++;
      $display("FAIL prio_data_ar got=%h want=%h", {arvalid, arid, araddr, inst_addr_ok},
               {1'b1, 4'd1, 32'h8000_1000, 1'b0});
    end
    step();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1111_2222;
    sample();
    checks++;
    if ({data_data_ok, inst_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL prio_no_early_inst got=%b want=10", {data_data_ok, inst_addr_ok});
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    sample();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL prio_inst_after got=%b want=10", {inst_addr_ok, data_addr_ok});
    end
    push_exp(1'b0, 1'b0, 32'h3333_4444);
    step();
    inst_req = 1'b0;
    sample();
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'hBFC0_0004}) begin
      errors++;
      $display("FAIL prio_inst_ar got=%h want=%h", {arvalid, arid, araddr},
               {1'b1, 4'd0, 32'hBFC0_0004});
    end
    step();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h3333_4444;
    sample();
    step();
    rvalid = 1'b0; rlast = 1'b0;
    sample();
  endtask

  task automatic test_byte_write();
    step();
    set_port(1'b1, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB);
    awready = 1'b0; wready = 1'b1; arready = 1'b0;
    sample();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL bw_addr_ok got=%b want=1", data_addr_ok);
    end
    push_exp(1'b1, 1'b1, 32'd0);
    step();
    data_req = 1'b0;
    sample();
    checks++;
    if ({awvalid, wvalid, awid, wid, awaddr, awsize, awlen, wstrb, wlast, wdata, bready} !==
        {1'b1, 1'b1, 4'd1, 4'd1, 32'h8000_0003, 3'd0, 4'd0, 4'b1000, 1'b1, 32'h0000_00AB, 1'b0}) begin
      errors++;
      $display("FAIL bw_first got=%h want=%h",
               {awvalid, wvalid, awid, wid, awaddr, awsize, awlen, wstrb, wlast, wdata, bready},
               {1'b1, 1'b1, 4'd1, 4'd1, 32'h8000_0003, 3'd0, 4'd0, 4'b1000, 1'b1, 32'h0000_00AB, 1'b0});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      sample();
      checks++;
      if ({awvalid, wvalid, awaddr, bready} !== {1'b1, 1'b0, 32'h8000_0003, 1'b0}) begin
        errors++;
        $display("FAIL bw_aw_stall cycle=%0d got=%h want=%h", i, {awvalid, wvalid, awaddr, bready},
                 {1'b1, 1'b0, 32'h8000_0003, 1'b0});
      end
    end
    step();
    awready = 1'b1;
    sample();
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      errors++;
      $display("FAIL bw_aw_hs got=%b want=100", {awvalid, wvalid, bready});
    end
    step();
    awready = 1'b0;
    sample();
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      errors++;
      $display("FAIL bw_b_state got=%b want=001", {awvalid, wvalid, bready});
    end
    step();
    bvalid = 1'b1;
    sample();
    checks++;
    if ({bready, data_data_ok} !== 2'b11) begin
      errors++;
      $display("FAIL bw_bresp got=%b want=11", {bready, data_data_ok});
    end
    step();
    bvalid = 1'b0;
    sample();
    checks++;
    if (hs_vec() !== 9'd0) begin
      errors++;
      $display("FAIL bw_idle got=%b want=%b", hs_vec(), 9'd0);
    end
  endtask

  task automatic test_half_write_and_stall();
    step();
    set_port(1'b1, 1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'hBEEF_0000);
    awready = 1'b1; wready = 1'b1;
    sample();
    push_exp(1'b1, 1'b1, 32'd0);
    step();
    data_req = 1'b0;
    sample();
    checks++;
    if ({awvalid, wvalid, wstrb, awsize, wdata} !== {1'b1, 1'b1, 4'b1100, 3'd1, 32'hBEEF_0000}) begin
      errors++;
      $display("FAIL hw_fields got=%h want=%h", {awvalid, wvalid, wstrb, awsize, wdata},
               {1'b1, 1'b1, 4'b1100, 3'd1, 32'hBEEF_0000});
    end
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    sample();
    checks++;
    if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0011) begin
      errors++;
      $display("FAIL hw_same_cycle_hs got=%b want=0011", {awvalid, wvalid, bready, data_data_ok});
    end
    step();
    bvalid = 1'b0;
    set_port(1'b1, 1'b1, 1'b0, 2'd2, 32'h8000_2000, 32'd0);
    arready = 1'b0;
    sample();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL stall_addr_ok got=%b want=1", data_addr_ok);
    end
    push_exp(1'b1, 1'b0, 32'hCAFE_F00D);
    step();
    data_req = 1'b0;
    set_port(1'b0, 1'b1, 1'b0, 2'd2, 32'hBFC0_0100, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      sample();
      checks++;
      if ({arvalid, araddr, arsize, inst_addr_ok, data_addr_ok} !==
          {1'b1, 32'h8000_2000, 3'd2, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_ar cycle=%0d got=%h want=%h", i,
                 {arvalid, araddr, arsize, inst_addr_ok, data_addr_ok},
                 {1'b1, 32'h8000_2000, 3'd2, 1'b0, 1'b0});
      end
    end
    step();
    arready = 1'b1;
    sample();
    step();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_F00D;
    sample();
    checks++;
    if ({rready, inst_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL stall_r got=%b want=10", {rready, inst_addr_ok});
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    sample();
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL stall_inst_grant got=%b want=1", inst_addr_ok);
    end
    push_exp(1'b0, 1'b0, 32'h0BAD_BEEF);
    step();
    inst_req = 1'b0;
    arready = 1'b1;
    sample();
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'hBFC0_0100}) begin
      errors++;
      $display("FAIL stall_inst_ar got=%h want=%h", {arvalid, arid, araddr},
               {1'b1, 4'd0, 32'hBFC0_0100});
    end
    step();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0BAD_BEEF;
    sample();
    step();
    rvalid = 1'b0; rlast = 1'b0;
    sample();
  endtask

  task automatic test_reset_in_r();
    step();
    set_port(1'b0, 1'b1, 1'b0, 2'd2, 32'hBFC0_0200, 32'd0);
    arready = 1'b1;
    sample();
    push_exp(1'b0, 1'b0, 32'hDEAD_DEAD);
    step();
    inst_req = 1'b0;
    sample();
    step();
    sample();
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_r got=%b want=1", rready);
    end
    step();
    rst = 1'b1;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_DEAD;
    sample();
    step();
    rst = 1'b0;
    sb.delete();
    sample();
    checks++;
    if ({arvalid, rready, inst_data_ok, data_data_ok} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b want=0000", {arvalid, rready, inst_data_ok, data_data_ok});
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    set_port(1'b0, 1'b1, 1'b0, 2'd2, 32'hBFC0_0300, 32'd0);
    sample();
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_regrant got=%b want=1", inst_addr_ok);
    end
    push_exp(1'b0, 1'b0, 32'h1234_5678);
    step();
    inst_req = 1'b0;
    sample();
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'hBFC0_0300}) begin
      errors++;
      $display("FAIL rst_mid_ar got=%h want=%h", {arvalid, arid, araddr},
               {1'b1, 4'd0, 32'hBFC0_0300});
    end
    step();
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
    sample();
    step();
    rvalid = 1'b0; rlast = 1'b0;
    sample();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_inst_read();
    test_priority();
    test_byte_write();
    test_half_write_and_stall();
    test_reset_in_r();
    step();
    sample();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drained got=%0d pending want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
